vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; successor to the fixed 640x480 driver.
- Derives a pixel clock enable and VGA DAC clock from the 100 MHz system clock, and generates h/v counters, sync, blank, data-enable and frame/line markers.
- Provides a configurable sync pipeline delay so sync/blank align with downstream pixel logic.
- Sits between the system clock and the game-engine renderer/DAC.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_delay_line.sv | 27 ++
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing presets and total-length helper
package vga_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vga_axis_t;

  localparam vga_axis_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96,  bp: 48};
  localparam vga_axis_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,   bp: 33};
  localparam vga_axis_t VGA_800X600_H = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam vga_axis_t VGA_800X600_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};

  function automatic int vga_total(vga_axis_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enable-qualified shift register with preset reset value
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else if (en) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_640X480_H.active,
  parameter int H_FP       = VGA_640X480_H.fp,
  parameter int H_SYNC     = VGA_640X480_H.sync,
  parameter int H_BP       = VGA_640X480_H.bp,
  parameter int V_ACTIVE   = VGA_640X480_V.active,
  parameter int V_FP       = VGA_640X480_V.fp,
  parameter int V_SYNC     = VGA_640X480_V.sync,
  parameter int V_BP       = VGA_640X480_V.bp,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CLK_DIV    = 4,
  parameter int PIPE_DELAY = 0,
  parameter int XW         = 10,
  parameter int YW         = 10
) (
  input  logic          real100clock,
  input  logic          resetn,
  input  logic          enable,
  output logic          VGAclock,
  output logic          pixtick,
  output logic          hsync,
  output logic          vsync,
  output logic          VGAblanck,
  output logic          VGAsync,
  output logic          de,
  output logic [XW-1:0] xPixel,
  output logic [YW-1:0] yPixel,
  output logic          linestart,
  output logic          framestart
);

  localparam int H_TOTAL = vga_total(vga_axis_t'{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP});
  localparam int V_TOTAL = vga_total(vga_axis_t'{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP});
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_nxt;
  logic          vclk_q;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          tick;
  logic          x_wrap;
  logic          y_wrap;
  logic          hs_raw;
  logic          vs_raw;
  logic          act_raw;
  logic [2:0]    dly_in;
  logic [2:0]    dly_out;
  logic [XW-1:0] xpix_q;
  logic [YW-1:0] ypix_q;
  logic          ls_q;
  logic          fs_q;

  assign dcnt_nxt = (dcnt == D_LAST) ? '0 : dcnt + 1'b1;
  assign tick     = (dcnt == D_LAST) && enable;
  assign x_wrap   = (x == H_LAST);
  assign y_wrap   = (y == V_LAST);

  assign hs_raw  = (x >= HS_BEG) && (x < HS_END);
  assign vs_raw  = (y >= VS_BEG) && (y < VS_END);
  assign act_raw = (x < H_ACT) && (y < V_ACT);

  // Divider and pixel clock free-run; only the raster position obeys enable.
  always_ff @(posedge real100clock or negedge resetn) begin
    if (!resetn) begin
      dcnt   <= '0;
      vclk_q <= 1'b1;
    end else begin
      dcnt   <= dcnt_nxt;
      vclk_q <= (dcnt_nxt < D_HALF);
    end
  end

  // Outputs reflect the position held before the tick, so (0,0) is shown first.
  always_ff @(posedge real100clock or negedge resetn) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      xpix_q <= '0;
      ypix_q <= '0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      ls_q <= tick && x_wrap;
      fs_q <= tick && x_wrap && y_wrap;
      if (tick) begin
        x      <= x_wrap ? '0 : x + 1'b1;
        xpix_q <= act_raw ? XW'(x) : '0;
        ypix_q <= act_raw ? YW'(y) : '0;
        if (x_wrap) y <= y_wrap ? '0 : y + 1'b1;
      end
    end
  end

  assign dly_in = {hs_raw ? H_SYNC_POL : ~H_SYNC_POL,
                   vs_raw ? V_SYNC_POL : ~V_SYNC_POL,
                   act_raw};

  // One stage matches the xPixel register; PIPE_DELAY further stages follow it.
  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DELAY + 1),
    .RST_VAL ({~H_SYNC_POL, ~V_SYNC_POL, 1'b0})
  ) u_sync_dly (
    .clk    (real100clock),
    .resetn (resetn),
    .en     (tick),
    .din    (dly_in),
    .dout   (dly_out)
  );

  assign VGAclock   = vclk_q;
  assign pixtick    = tick;
  assign hsync      = dly_out[2];
  assign vsync      = dly_out[1];
  assign VGAblanck  = dly_out[0];
  assign de         = dly_out[0];
  assign VGAsync    = 1'b0;
  assign xPixel     = xpix_q;
  assign yPixel     = ypix_q;
  assign linestart  = ls_q;
  assign framestart = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rstn, en;
  logic [2:0] vclk, tick, hs, vs, blank, vsyn, de_o, ls, fs;
  logic [2:0][9:0] xp, yp;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int div_c [3] = '{2, 2, 4};
  int pd_c  [3] = '{0, 3, 0};
  logic [2:0] hpol_c = 3'b100;

  // Model state: k = system edges since release, n = pixel ticks taken.
  int k [3];
  int n [3];
  logic [2:0] ls_m, fs_m;

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .CLK_DIV(2), .PIPE_DELAY(0), .XW(10), .YW(10)) dut0 (
    .real100clock(clk), .resetn(rstn[0]), .enable(en[0]), .VGAclock(vclk[0]), .pixtick(tick[0]),
    .hsync(hs[0]), .vsync(vs[0]), .VGAblanck(blank[0]), .VGAsync(vsyn[0]), .de(de_o[0]),
    .xPixel(xp[0]), .yPixel(yp[0]), .linestart(ls[0]), .framestart(fs[0]));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .CLK_DIV(2), .PIPE_DELAY(3), .XW(10), .YW(10)) dut1 (
    .real100clock(clk), .resetn(rstn[1]), .enable(en[1]), .VGAclock(vclk[1]), .pixtick(tick[1]),
    .hsync(hs[1]), .vsync(vs[1]), .VGAblanck(blank[1]), .VGAsync(vsyn[1]), .de(de_o[1]),
    .xPixel(xp[1]), .yPixel(yp[1]), .linestart(ls[1]), .framestart(fs[1]));

  vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0),
    .CLK_DIV(4), .PIPE_DELAY(0), .XW(10), .YW(10)) dut2 (
    .real100clock(clk), .resetn(rstn[2]), .enable(en[2]), .VGAclock(vclk[2]), .pixtick(tick[2]),
    .hsync(hs[2]), .vsync(vs[2]), .VGAblanck(blank[2]), .VGAsync(vsyn[2]), .de(de_o[2]),
    .xPixel(xp[2]), .yPixel(yp[2]), .linestart(ls[2]), .framestart(fs[2]));

  function automatic logic mtick(int i);
    return en[i] && ((k[i] % div_c[i]) == div_c[i] - 1);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (!rstn[i]) begin
        k[i] <= 0;
        n[i] <= 0;
        ls_m[i] <= 1'b0;
        fs_m[i] <= 1'b0;
      end else begin
        ls_m[i] <= mtick(i) && (n[i] % HT == HT - 1);
        fs_m[i] <= mtick(i) && (n[i] % (HT * VT) == HT * VT - 1);
        if (mtick(i)) n[i] <= n[i] + 1;
        k[i] <= k[i] + 1;
      end
    end
  end

  // Raster rules on a linear pixel index m (m < 0: before the first pixel).
  function automatic bit in_act(int m);
    return (m >= 0) && (m % HT < HA) && ((m / HT) % VT < VA);
  endfunction
  function automatic bit hs_on(int m);
    return (m >= 0) && (m % HT >= HA + HFP) && (m % HT < HA + HFP + HSW);
  endfunction
  function automatic bit vs_on(int m);
    return (m >= 0) && ((m / HT) % VT >= VA + VFP) && ((m / HT) % VT < VA + VFP + VSW);
  endfunction

  function automatic logic [8:0] exp_ctl(int i);
    int m;
    logic hs_e, vs_e, act_e, vc;
    if (!rstn[i]) return {1'b1, 1'b0, ~hpol_c[i], 1'b1, 5'b0};
    m     = n[i] - 1 - pd_c[i];
    hs_e  = hs_on(m) ? hpol_c[i] : ~hpol_c[i];
    vs_e  = vs_on(m) ? 1'b0 : 1'b1;
    act_e = in_act(m);
    vc    = (k[i] % div_c[i]) < (div_c[i] / 2);
    return {vc, mtick(i), hs_e, vs_e, act_e, act_e, ls_m[i], fs_m[i], 1'b0};
  endfunction

  function automatic logic [19:0] exp_pix(int i);
    int m;
    if (!rstn[i]) return 20'd0;
    m = n[i] - 1;
    if (!in_act(m)) return 20'd0;
    return {10'(m % HT), 10'((m / HT) % VT)};
  endfunction

  function automatic logic [8:0] ctl_obs(int i);
    return {vclk[i], tick[i], hs[i], vs[i], blank[i], de_o[i], ls[i], fs[i], vsyn[i]};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (ctl_obs(i) !== exp_ctl(i)) begin
        n_fail++;
        $display("FAIL reset_ctl dut%0d got %b required %b", i, ctl_obs(i), exp_ctl(i));
      end
      n_tests++;
      if ({xp[i], yp[i]} !== 20'd0) begin
        n_fail++;
        $display("FAIL reset_pix dut%0d got %h required 0", i, {xp[i], yp[i]});
      end
    end
  endtask

  task automatic test_raster();
    int last_fs = -1;
    int nfs = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      n_tests++;
      if (ctl_obs(0) !== exp_ctl(0)) begin
        n_fail++;
        $display("FAIL raster_ctl cyc=%0d got %b required %b", cyc, ctl_obs(0), exp_ctl(0));
      end
      n_tests++;
      if ({xp[0], yp[0]} !== exp_pix(0)) begin
        n_fail++;
        $display("FAIL raster_pix cyc=%0d got %h required %h", cyc, {xp[0], yp[0]}, exp_pix(0));
      end
      if (fs[0] === 1'b1) begin
        if (last_fs >= 0) begin
          n_tests++;
          if (cyc - last_fs != 256) begin
            n_fail++;
            $display("FAIL frame_period got %0d required 256", cyc - last_fs);
          end
        end
        last_fs = cyc;
        nfs++;
      end
    end
    n_tests++;
    if (nfs < 2) begin
      n_fail++;
      $display("FAIL frame_count got %0d required >=2", nfs);
    end
  endtask

  task automatic test_pipe_delay();
    logic prev_hs = hs[1];
    int falls = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      n_tests++;
      if (ctl_obs(1) !== exp_ctl(1)) begin
        n_fail++;
        $display("FAIL pipe_ctl cyc=%0d got %b required %b", cyc, ctl_obs(1), exp_ctl(1));
      end
      n_tests++;
      if ({xp[1], yp[1]} !== exp_pix(1)) begin
        n_fail++;
        $display("FAIL pipe_pix cyc=%0d got %h required %h", cyc, {xp[1], yp[1]}, exp_pix(1));
      end
      if (prev_hs === 1'b1 && hs[1] === 1'b0) begin
        falls++;
        n_tests++;
        if ((n[1] - 1) % HT != HA + HFP + 3) begin
          n_fail++;
          $display("FAIL pipe_hs_fall at x=%0d required %0d", (n[1] - 1) % HT, HA + HFP + 3);
        end
      end
      prev_hs = hs[1];
    end
    n_tests++;
    if (falls == 0) begin
      n_fail++;
      $display("FAIL pipe_hs_fall_count got 0 required >0");
    end
  endtask

  task automatic test_enable();
    bit found = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      n_tests++;
      if (ctl_obs(0) !== exp_ctl(0) || {xp[0], yp[0]} !== exp_pix(0)) begin
        n_fail++;
        $display("FAIL enable_rand cyc=%0d got %b/%h required %b/%h", cyc, ctl_obs(0),
                 {xp[0], yp[0]}, exp_ctl(0), exp_pix(0));
      end
      en[0] = ($urandom_range(0, 3) != 0);
    end
    en[0] = 1'b1;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (n[0] % (HT * VT) == 2 * HT + 5) found = 1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL enable_seek got none required x=5,y=2");
    end
    en[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_tests++;
      if (ctl_obs(0) !== exp_ctl(0)) begin
        n_fail++;
        $display("FAIL freeze_ctl cyc=%0d got %b required %b", cyc, ctl_obs(0), exp_ctl(0));
      end
      n_tests++;
      if ({xp[0], yp[0]} !== {10'd4, 10'd2}) begin
        n_fail++;
        $display("FAIL freeze_pix got %0d,%0d required 4,2", xp[0], yp[0]);
      end
    end
    en[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_tests++;
      if (ctl_obs(0) !== exp_ctl(0) || {xp[0], yp[0]} !== exp_pix(0)) begin
        n_fail++;
        $display("FAIL resume cyc=%0d got %b/%h required %b/%h", cyc, ctl_obs(0),
                 {xp[0], yp[0]}, exp_ctl(0), exp_pix(0));
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (n[0] % HT == HA + HFP + 2) found = 1;
    end
    n_tests++;
    if (!found || hs[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_seek found=%0d hsync=%b required 1/0", found, hs[0]);
    end
    #1 rstn[0] = 1'b0;
    #1;
    n_tests++;
    if (ctl_obs(0) !== exp_ctl(0) || {xp[0], yp[0]} !== 20'd0) begin
      n_fail++;
      $display("FAIL midreset_async got %b/%h required %b/0", ctl_obs(0), {xp[0], yp[0]}, exp_ctl(0));
    end
    repeat ($urandom_range(1, 4)) @(negedge clk);
    rstn[0] = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      n_tests++;
      if (ctl_obs(0) !== exp_ctl(0) || {xp[0], yp[0]} !== exp_pix(0)) begin
        n_fail++;
        $display("FAIL midreset_run cyc=%0d got %b/%h required %b/%h", cyc, ctl_obs(0),
                 {xp[0], yp[0]}, exp_ctl(0), exp_pix(0));
      end
    end
  endtask

  task automatic test_clkdiv_pol();
    logic prev_vc = vclk[2];
    int run = 0;
    int hs_hi = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_tests++;
      if (ctl_obs(2) !== exp_ctl(2) || {xp[2], yp[2]} !== exp_pix(2)) begin
        n_fail++;
        $display("FAIL div4_run cyc=%0d got %b/%h required %b/%h", cyc, ctl_obs(2),
                 {xp[2], yp[2]}, exp_ctl(2), exp_pix(2));
      end
      if (vclk[2] === 1'b1) run++;
      if (prev_vc === 1'b1 && vclk[2] === 1'b0) begin
        n_tests++;
        if (run != 2) begin
          n_fail++;
          $display("FAIL vgaclk_high got %0d required 2", run);
        end
        run = 0;
      end
      if (hs[2] === 1'b1) hs_hi++;
      prev_vc = vclk[2];
    end
    n_tests++;
    if (hs_hi != 0 && hs_hi == 600) begin
      n_fail++;
      $display("FAIL hs_pol_stuck got %0d high cycles required partial", hs_hi);
    end
    n_tests++;
    if (hs_hi == 0) begin
      n_fail++;
      $display("FAIL hs_pol_high got 0 high cycles required >0");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rstn = 3'b000;
    en   = 3'b111;
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 3'b111;
    test_raster();
    test_pipe_delay();
    test_enable();
    test_reset_midframe();
    test_clkdiv_pol();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
